ccff_stream_loader: RTL and testbench
=====================================

Name: ccff_stream_loader

Overview:
- Configuration-chain driver that sits directly upstream of a tile's ccff_head input, i.e. ahead of the switch-block/connection-block configuration flip-flop chain.
- Accepts bitstream words over a valid/ready interface and serializes exactly CHAIN_LEN bits onto ccff_head, one bit per enabled prog_clk edge.
- Packs the bits that fall out of ccff_tail (the previous configuration) into readback words on a second valid/ready interface.
- Drives chain_en, which the external clock gate uses to gate prog_clk to the chain.

Parameters:
- CHAIN_LEN, 6, number of configuration flops in the downstream chain (>=1).
- WORD_W, 4, bitstream/readback word width (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived).

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- prog_reset_n  in  1  reset, asynchronous assert, active low.
- start  in  1  one-cycle pulse; begins a load. Ignored unless in IDLE.
- abort  in  1  returns the block to IDLE from any state on the next edge.
- wr_data  in  WORD_W  bitstream word, MSB shifted first.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  loader accepts wr_data this cycle.
- rd_data  out  WORD_W  readback word, MSB = first bit out of ccff_tail.
- rd_valid  out  1  rd_data valid; held until rd_ready.
- rd_ready  in  1  consumer accepts rd_data.
- ccff_head  out  1  serial data into the chain.
- chain_en  out  1  chain shifts at the next prog_clk edge.
- ccff_tail  in  1  serial data out of the chain.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last readback word is accepted.

Behaviour:
- Reset (async, prog_reset_n=0): state=IDLE; wr_ready, rd_valid, chain_en, ccff_head, busy and done all 0; rd_data=0; all counters 0.
- States and transitions:
  - IDLE: start -> FETCH; bit counter cleared.
  - FETCH: wr_ready=1. On wr_valid&&wr_ready, the word is latched into the shift register and the state moves to SHIFT.
  - SHIFT: each cycle that is not stalled drives ccff_head=shreg[MSB] and chain_en=1, then shifts shreg left and increments bits_done.
    - The word ends after WORD_W bits, or earlier when bits_done reaches CHAIN_LEN.
    - On word end: if bits_done==CHAIN_LEN go to DRAIN, otherwise go to FETCH.
  - DRAIN: wait until the final readback word is handed off, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Registered outputs: ccff_head and chain_en are registered. The chain samples ccff_head at the edge that ends a chain_en=1 cycle.
- Readback capture:
  - At every edge ending a chain_en=1 cycle, the loader samples ccff_tail (the pre-shift value) into a readback shifter, MSB first.
  - After WORD_W captured bits, or after the CHAIN_LEN-th bit, the word moves to rd_data and rd_valid is set.
  - A partial last word is MSB-aligned with its unused LSBs 0.
- Backpressure: if rd_valid=1 and rd_ready=0 and another readback word would complete, SHIFT stalls with chain_en=0 until handoff. The chain never shifts while a completed word is unsent.
- Last word: the last input word uses only its top (CHAIN_LEN mod WORD_W) bits when that value is nonzero. The ignored LSBs are never driven onto ccff_head.
- Words per load: exactly ceil(CHAIN_LEN/WORD_W) words in each direction. The total count of chain_en=1 cycles per load equals CHAIN_LEN.
- Simultaneous events:
  - start while busy is ignored.
  - abort has priority over every other event; start and abort together in IDLE stays in IDLE.
  - rd handoff and a new capture completing in the same cycle is allowed: rd_data is reloaded with no gap.
- Abort mid-load: chain_en drops the next cycle. Partial readback is discarded (rd_valid=0), done is not pulsed, and the chain is left partially shifted.
- Reset mid-load: same as abort, but immediate.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT, DRAIN, DONE);
  - a function words_for(CHAIN_LEN, WORD_W) = ceil division;
  - the per-tile CHAIN_LEN constants, e.g. SB_0__0_CHAIN_LEN=6.
- One natural sub-module: ccff_word_packer, the serial-to-word readback shifter with its valid/ready output register. The main FSM instantiates it.

Test Plan:
- Basic load, CHAIN_LEN=6, WORD_W=4, chain model preloaded with 6'b101100:
  - Stimulus: start, then words 4'b1101 and 4'b01xx.
  - ccff_head sequence 1,1,0,1,0,1 with six chain_en cycles; chain model ends at 6'b110101.
  - rd words 4'b1011 then 4'b0000; done pulses once.
- Double load: load 6'b110101 twice. The second readback returns 4'b1101 and 4'b0100, confirming the first load.
- Readback backpressure: hold rd_ready=0 for 10 cycles after the first rd_valid. chain_en must stay 0 once the second word completes, and no bits may be lost.
- Write starvation: wr_valid=0 for 5 cycles between words. The block sits in FETCH with chain_en=0, and the output matches the basic load.
- Abort after 3 shifted bits:
  - busy falls the next cycle; done and rd_valid are never asserted.
  - A subsequent start performs a full clean 6-bit load.
- Async reset asserted mid-SHIFT: all outputs go to 0 immediately, independent of prog_clk. After release the state is IDLE and start is accepted.

Source files
------------

// File: rtl/ccff_pkg.sv
// ccff_pkg: shared state type, sizing helper and per-tile chain lengths for the configuration loader
package ccff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        DRAIN,
        DONE
    } ccff_state_e;

    localparam int SB_0__0_CHAIN_LEN   = 6;
    localparam int CBX_1__0_CHAIN_LEN  = 4;
    localparam int CBY_0__1_CHAIN_LEN  = 4;

    function automatic int words_for(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_packer.sv
// ccff_word_packer: packs bits falling out of ccff_tail into MSB-first readback words behind a valid/ready register
module ccff_word_packer #(
    parameter int CHAIN_LEN = 6,
    parameter int WORD_W    = 4,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              clr_i,
    input  logic              cap_en_i,
    input  logic              cap_bit_i,
    input  logic              rd_ready_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    output logic              full_next_o
);

    localparam int IDX_W = $clog2(WORD_W + 1);
    localparam logic [WORD_W-1:0] MSB_BIT = WORD_W'(1) << (WORD_W - 1);

    logic [WORD_W-1:0] acc_q, acc_d, acc_set, data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  tot_q, tot_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic              last_bit, word_done;

    // Place each captured bit at its MSB-first slot; a word closes on a full word or on the final chain bit.
    always_comb begin
        last_bit    = tot_q == CNT_W'(CHAIN_LEN - 1);
        word_done   = cap_en_i && (idx_q == IDX_W'(WORD_W - 1) || last_bit);
        acc_set     = cap_bit_i ? acc_q | (MSB_BIT >> idx_q) : acc_q;
        acc_d       = clr_i ? '0 : cap_en_i ? (word_done ? '0 : acc_set) : acc_q;
        idx_d       = clr_i ? '0 : cap_en_i ? (word_done ? '0 : idx_q + 1'b1) : idx_q;
        tot_d       = clr_i ? '0 : cap_en_i ? tot_q + 1'b1 : tot_q;
        valid_d     = !clr_i && (word_done || (valid_q && !rd_ready_i));
        data_d      = clr_i ? '0 : word_done ? acc_set : data_q;
        last_d      = !clr_i && (word_done ? last_bit : last_q);
        full_next_o = (valid_q && !rd_ready_i) || word_done;
    end

    // Accumulator, counters and the output holding register.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            acc_q   <= '0;
            idx_q   <= '0;
            tot_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            tot_q   <= tot_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign rd_data_o  = data_q;
    assign rd_valid_o = valid_q;
    assign rd_last_o  = last_q;

endmodule

// File: rtl/ccff_stream_loader.sv
// ccff_stream_loader: serializes bitstream words onto ccff_head and returns the displaced chain contents as readback words
module ccff_stream_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = SB_0__0_CHAIN_LEN,
    parameter int WORD_W    = 4,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              ccff_head,
    output logic              chain_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(WORD_W + 1);

    ccff_state_e       state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  bits_done_q, bits_done_d;
    logic              head_q, head_d, en_q, en_d;
    logic              last_bit, word_end, full_next, rd_last, clr;

    // Next state: a word-ending bit is held back while the readback slot cannot take the word it completes.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        bits_done_d = bits_done_q;
        head_d      = 1'b0;
        en_d        = 1'b0;
        last_bit    = bits_done_q == CNT_W'(CHAIN_LEN - 1);
        word_end    = bit_idx_q == IDX_W'(WORD_W - 1) || last_bit;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH;
                    bits_done_d = '0;
                end
            end
            FETCH: begin
                if (wr_valid) begin
                    state_d   = SHIFT;
                    shreg_d   = wr_data;
                    bit_idx_d = '0;
                end
            end
            SHIFT: begin
                if (!(word_end && full_next)) begin
                    en_d        = 1'b1;
                    head_d      = shreg_q[WORD_W-1];
                    shreg_d     = shreg_q << 1;
                    bit_idx_d   = bit_idx_q + 1'b1;
                    bits_done_d = bits_done_q + 1'b1;
                    if (word_end) state_d = last_bit ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                if (rd_valid && rd_ready && rd_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            head_d  = 1'b0;
            en_d    = 1'b0;
        end
    end

    // State, shift register, counters and the registered chain drive.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            bits_done_q <= '0;
            head_q      <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            bits_done_q <= bits_done_d;
            head_q      <= head_d;
            en_q        <= en_d;
        end
    end

    assign clr       = abort || (state_q == IDLE && start);
    assign wr_ready  = state_q == FETCH;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign ccff_head = head_q;
    assign chain_en  = en_q;

    ccff_word_packer #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) u_packer (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .clr_i       (clr),
        .cap_en_i    (en_q),
        .cap_bit_i   (ccff_tail),
        .rd_ready_i  (rd_ready),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .rd_last_o   (rd_last),
        .full_next_o (full_next)
    );

endmodule

// File: tb/tb_ccff_stream_loader.sv
// tb_ccff_stream_loader: randomized loads against a chain model and queue-based expectations
module tb_ccff_stream_loader;

    localparam int L  = 6;
    localparam int W  = 4;
    localparam int NW = (L + W - 1) / W;

    logic         prog_clk = 1'b0, prog_reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic         wr_valid = 1'b0, rd_ready = 1'b1;
    logic [W-1:0] wr_data = '0;
    logic         wr_ready, rd_valid, ccff_head, chain_en, busy, done, ccff_tail;
    logic [W-1:0] rd_data;
    logic [L-1:0] chain = 6'b101100;
    logic [L-1:0] got_head = '0;
    logic [W-1:0] pend_d = '0;
    logic [W-1:0] exp_rd[$], got_rd[$];
    bit           exp_head[$];
    bit           bp_used = 0, pend_v = 0;
    int           n_cmp = 0, n_bad = 0, en_cnt = 0, n_done = 0, n_rdv = 0, bp_mode = 0, bp_hold = 0;

    ccff_stream_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .start       (start),
        .abort       (abort),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .ccff_head   (ccff_head),
        .chain_en    (chain_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done)
    );

    always #5 prog_clk = ~prog_clk;

    // Downstream configuration chain: shifts ccff_head in whenever the gated clock is enabled.
    assign ccff_tail = chain[L-1];
    always @(posedge prog_clk) if (chain_en) chain <= {chain[L-2:0], ccff_head};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Compare process: every shifted bit, every readback handoff, hold stability and done.
    always @(negedge prog_clk) if (prog_reset_n) begin
        if (chain_en) begin
            if (exp_head.size() == 0) chk("head_extra", 32'd1, 32'd0);
            else chk("ccff_head", 32'(ccff_head), 32'(exp_head.pop_front()));
            if (rd_valid && !rd_ready)
                chk("bp_stall", 32'(en_cnt % W == W - 1 || en_cnt == L - 1), 32'd0);
            got_head = {got_head[L-2:0], ccff_head};
            en_cnt++;
        end
        if (rd_valid && rd_ready) begin
            if (exp_rd.size() == 0) chk("rd_extra", 32'd1, 32'd0);
            else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            got_rd.push_back(rd_data);
        end
        if (pend_v) chk("rd_hold", 32'({rd_valid, rd_data}), 32'({1'b1, pend_d}));
        pend_v = rd_valid && !rd_ready;
        pend_d = rd_data;
        if (done) begin
            chk("done_bits", en_cnt, L);
            chk("done_rdq", exp_rd.size(), 0);
            n_done++;
        end
        if (rd_valid) n_rdv++;
    end

    // Readback consumer: always ready, random, or a 10-cycle stall after the first valid word.
    initial forever begin
        @(posedge prog_clk);
        #1;
        if (bp_mode == 2 && rd_valid && !bp_used) begin
            bp_hold = 10;
            bp_used = 1;
        end
        rd_ready = bp_mode == 1 ? 1'($urandom_range(1)) : bp_hold == 0;
        if (bp_hold > 0) bp_hold--;
    end

    task automatic run_load(input logic [L-1:0] payload, input int gap, input int stop_at, input bit use_reset);
        logic [W-1:0] word;
        int d0, r0, ok;
        @(posedge prog_clk);
        #1;
        exp_head.delete();
        exp_rd.delete();
        got_rd.delete();
        en_cnt   = 0;
        got_head = '0;
        bp_used  = 0;
        pend_v   = 0;
        for (int i = 0; i < L; i++) exp_head.push_back(payload[L-1-i]);
        for (int w = 0; w < NW; w++) begin
            word = '0;
            for (int b = 0; b < W; b++) if (w * W + b < L) word[W-1-b] = chain[L-1-(w*W+b)];
            exp_rd.push_back(word);
        end
        d0 = n_done;
        r0 = n_rdv;
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
        for (int w = 0; w < NW; w++) begin
            repeat (gap < 0 ? int'($urandom_range(3)) : gap) begin
                @(posedge prog_clk);
                #1;
            end
            word = W'($urandom);
            for (int b = 0; b < W; b++) if (w * W + b < L) word[W-1-b] = payload[L-1-(w*W+b)];
            wr_data  = word;
            wr_valid = 1'b1;
            ok       = 0;
            for (int c = 0; c < 200 && ok == 0; c++) begin
                @(negedge prog_clk);
                if (wr_ready) ok = 1;
                @(posedge prog_clk);
                #1;
            end
            wr_valid = 1'b0;
            chk("wr_accept", ok, 1);
            if (stop_at > 0) break;
        end
        if (stop_at > 0) begin
            for (int c = 0; c < 200 && en_cnt < stop_at; c++) begin
                @(negedge prog_clk);
                #1;
            end
            if (use_reset) begin
                #2 prog_reset_n = 1'b0;
                #1;
                chk("rst_chain_en", 32'(chain_en), 32'd0);
                chk("rst_head", 32'(ccff_head), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_rd", 32'({rd_valid, rd_data, wr_ready, done}), 32'd0);
                #23 prog_reset_n = 1'b1;
            end else begin
                abort = 1'b1;
                @(posedge prog_clk);
                #1;
                abort = 1'b0;
                @(negedge prog_clk);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_en", 32'(chain_en), 32'd0);
                repeat (3) @(negedge prog_clk);
                chk("abort_bits", en_cnt, stop_at);
            end
            chk("stop_no_done", n_done - d0, 0);
            chk("stop_no_rdv", n_rdv - r0, 0);
            exp_head.delete();
            exp_rd.delete();
            pend_v = 0;
            return;
        end
        for (int c = 0; c < 400 && n_done == d0; c++) begin
            @(negedge prog_clk);
            #1;
        end
        chk("done_seen", n_done - d0, 1);
        repeat (3) @(negedge prog_clk);
        chk("done_once", n_done - d0, 1);
        chk("idle_after", 32'(busy), 32'd0);
        chk("chain_final", 32'(chain), 32'(payload));
        chk("rd_count", got_rd.size(), NW);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #8;
        chk("reset_wr_ready", 32'(wr_ready), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_chain_en", 32'(chain_en), 32'd0);
        chk("reset_head", 32'(ccff_head), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        #4 prog_reset_n = 1'b1;
        run_load(6'b110101, 0, 0, 0);
        chk("lit_head", 32'(got_head), 32'(6'b110101));
        chk("lit_rd0", 32'(got_rd[0]), 32'(4'b1011));
        chk("lit_rd1", 32'(got_rd[1]), 32'(4'b0000));
        chk("lit_chain", 32'(chain), 32'(6'b110101));
        run_load(6'b110101, 0, 0, 0);
        chk("lit2_rd0", 32'(got_rd[0]), 32'(4'b1101));
        chk("lit2_rd1", 32'(got_rd[1]), 32'(4'b0100));
        bp_mode = 2;
        run_load(L'($urandom), 0, 0, 0);
        bp_mode = 0;
        run_load(L'($urandom), 5, 0, 0);
        run_load(L'($urandom), 0, 3, 0);
        run_load(L'($urandom), 0, 0, 0);
        run_load(L'($urandom), 0, 2, 1);
        run_load(L'($urandom), 0, 0, 0);
        @(posedge prog_clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge prog_clk);
        chk("start_abort_idle", 32'(busy), 32'd0);
        bp_mode = 1;
        repeat (20) run_load(L'($urandom), -1, 0, 0);
        bp_mode = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
